// File: rtl/pc_unit.sv
// Program-counter stage: registered fetch address with jump/branch/call/return decode.
// Build with PC_UNIT_RAS_EN defined to include the return-address stack; without it pc_sel=11 is a plain jump.
module pc_unit #(
    parameter int unsigned       ADDR_W      = 16,
    parameter int unsigned       STACK_DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_enable,
    input  logic [1:0]        pc_sel,
    input  logic [ADDR_W-1:0] target,
    input  logic              branch_taken,
    input  logic              ret,
    output logic [ADDR_W-1:0] pc_out,
    output logic              stack_full,
    output logic              stack_empty,
    output logic              stack_err
);

    typedef enum logic [1:0] {
        SEL_SEQ     = 2'b00,
        SEL_JUMP    = 2'b01,
        SEL_BRANCH  = 2'b10,
        SEL_CALLRET = 2'b11
    } sel_e;

    sel_e              sel;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] pc_inc;

    assign sel    = sel_e'(pc_sel);
    assign pc_inc = pc_q + ADDR_W'(1);

`ifdef PC_UNIT_RAS_EN
    localparam int unsigned PTR_W = $clog2(STACK_DEPTH) + 1;
    localparam int unsigned IDX_W = PTR_W - 1;

    logic [ADDR_W-1:0] ras_mem [STACK_DEPTH];
    logic [PTR_W-1:0]  sp_q;
    logic [PTR_W-1:0]  sp_next;
    logic [IDX_W-1:0]  push_idx;
    logic [IDX_W-1:0]  pop_idx;
    logic              err_q;
    logic              err_next;
    logic              push;
    logic              ras_full;
    logic              ras_empty;

    assign ras_full  = (sp_q == PTR_W'(STACK_DEPTH));
    assign ras_empty = (sp_q == '0);
    assign push_idx  = sp_q[IDX_W-1:0];
    // Power-of-two depth lets the index wrap naturally when the pointer is at STACK_DEPTH.
    assign pop_idx   = push_idx - IDX_W'(1);
`endif

    always_comb begin
        pc_next = pc_q;
`ifdef PC_UNIT_RAS_EN
        sp_next  = sp_q;
        err_next = err_q;
        push     = 1'b0;
`endif
        if (pc_enable) begin
            case (sel)
                SEL_SEQ:    pc_next = pc_inc;
                SEL_JUMP:   pc_next = target;
                SEL_BRANCH: pc_next = branch_taken ? target : pc_inc;
                SEL_CALLRET: begin
`ifdef PC_UNIT_RAS_EN
                    if (!ret) begin
                        if (ras_full) begin
                            err_next = 1'b1;
                        end else begin
                            push    = 1'b1;
                            sp_next = sp_q + PTR_W'(1);
                            pc_next = target;
                        end
                    end else begin
                        if (ras_empty) begin
                            err_next = 1'b1;
                        end else begin
                            sp_next = sp_q - PTR_W'(1);
                            pc_next = ras_mem[pop_idx];
                        end
                    end
`else
                    pc_next = target;
`endif
                end
                default: pc_next = pc_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_next;
        end
    end

    assign pc_out = pc_q;

`ifdef PC_UNIT_RAS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_q  <= '0;
            err_q <= 1'b0;
        end else begin
            sp_q  <= sp_next;
            err_q <= err_next;
        end
    end

    // Entry contents are don't-care after reset, so the storage carries no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            ras_mem[push_idx] <= pc_inc;
        end
    end

    assign stack_full  = ras_full;
    assign stack_empty = ras_empty;
    assign stack_err   = err_q;
`else
    logic unused_ret;
    assign unused_ret  = ret;

    assign stack_full  = 1'b0;
    assign stack_empty = 1'b1;
    assign stack_err   = 1'b0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: behavioural PC/RAS model feeds a scoreboard queue.
// Expectations follow PC_UNIT_RAS_EN the same way the design build does.
module tb_pc_unit;

    localparam int DEPTH = 8;
`ifdef PC_UNIT_RAS_EN
    localparam bit RAS = 1'b1;
`else
    localparam bit RAS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pc_enable = 1'b0;
    logic [1:0]  pc_sel = 2'b00;
    logic [15:0] target = '0;
    logic        branch_taken = 1'b0;
    logic        ret = 1'b0;
    logic [15:0] pc_out;
    logic        stack_full;
    logic        stack_empty;
    logic        stack_err;

    pc_unit #(.ADDR_W(16), .STACK_DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_enable    (pc_enable),
        .pc_sel       (pc_sel),
        .target       (target),
        .branch_taken (branch_taken),
        .ret          (ret),
        .pc_out       (pc_out),
        .stack_full   (stack_full),
        .stack_empty  (stack_empty),
        .stack_err    (stack_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic        full;
        logic        empty;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] m_pc;
    logic [15:0] m_stk[$];
    logic        m_err;
    int          compared = 0;
    int          mismatched = 0;

    task automatic apply_reset();
        @(negedge clk);
        pc_enable = 1'b0;
        #2 rst = 1'b1;
        m_pc = 16'h0000;
        m_stk.delete();
        m_err = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Drives one cycle of stimulus, advances the model and queues the expected post-edge state.
    task automatic drive(input logic en, input logic [1:0] sel, input logic [15:0] tgt,
                         input logic bt, input logic rt);
        exp_t e;
        @(negedge clk);
        pc_enable = en; pc_sel = sel; target = tgt; branch_taken = bt; ret = rt;
        if (en) begin
            case (sel)
                2'b00: m_pc = m_pc + 16'd1;
                2'b01: m_pc = tgt;
                2'b10: m_pc = bt ? tgt : m_pc + 16'd1;
                default: begin
                    if (!RAS) m_pc = tgt;
                    else if (!rt) begin
                        if (m_stk.size() >= DEPTH) m_err = 1'b1;
                        else begin m_stk.push_back(m_pc + 16'd1); m_pc = tgt; end
                    end else begin
                        if (m_stk.size() == 0) m_err = 1'b1;
                        else m_pc = m_stk.pop_back();
                    end
                end
            endcase
        end
        e.pc    = m_pc;
        e.full  = RAS && (m_stk.size() == DEPTH);
        e.empty = !RAS || (m_stk.size() == 0);
        e.err   = RAS && m_err;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e;
        apply_reset();
        compared++;
        if ({pc_out, stack_full, stack_empty, stack_err} !== {16'h0000, 1'b0, 1'b1, 1'b0}) begin
            mismatched++;
            $display("FAIL reset_state: got pc=%h f/e/err=%b%b%b, want pc=0000 f/e/err=010",
                     pc_out, stack_full, stack_empty, stack_err);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'b00, 16'h0000, 1'b0, 1'b0);
            @(posedge clk); #1;
            e = sb.pop_front();
            compared++;
            if ({pc_out, stack_full, stack_empty, stack_err} !== {e.pc, e.full, e.empty, e.err}) begin
                mismatched++;
                $display("FAIL seq_step%0d: got pc=%h f/e/err=%b%b%b, want pc=%h f/e/err=%b%b%b", i,
                         pc_out, stack_full, stack_empty, stack_err, e.pc, e.full, e.empty, e.err);
            end
        end
        // asynchronous reset between edges must take effect without a clock
        #2 rst = 1'b1;
        #1;
        compared++;
        if ({pc_out, stack_empty, stack_err} !== {16'h0000, 1'b1, 1'b0}) begin
            mismatched++;
            $display("FAIL async_reset: got pc=%h e/err=%b%b, want pc=0000 e/err=10",
                     pc_out, stack_empty, stack_err);
        end
        m_pc = 16'h0000; m_stk.delete(); m_err = 1'b0;
        pc_enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_wrap();
        exp_t e;
        logic        en_t[7]  = '{1, 1, 1, 0, 1, 1, 1};
        logic [1:0]  sel_t[7] = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b11, 2'b01, 2'b11};
        logic [15:0] tgt_t[7] = '{16'hFFFF, 0, 16'hFFFF, 0, 16'h0020, 16'h0123, 0};
        logic        rt_t[7]  = '{0, 0, 0, 0, 0, 0, 1};
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            drive(en_t[i], sel_t[i], tgt_t[i], 1'b0, rt_t[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            compared++;
            if ({pc_out, stack_full, stack_empty, stack_err} !== {e.pc, e.full, e.empty, e.err}) begin
                mismatched++;
                $display("FAIL wrap_step%0d: got pc=%h f/e/err=%b%b%b, want pc=%h f/e/err=%b%b%b", i,
                         pc_out, stack_full, stack_empty, stack_err, e.pc, e.full, e.empty, e.err);
            end
        end
    endtask

    task automatic test_branch();
        exp_t e;
        logic [1:0]  sel_t[4] = '{2'b10, 2'b10, 2'b10, 2'b10};
        logic [15:0] tgt_t[4] = '{16'h0040, 16'h0040, 16'h0777, 16'h1234};
        logic        bt_t[4]  = '{1, 0, 0, 1};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, sel_t[i], tgt_t[i], bt_t[i], 1'b0);
            @(posedge clk); #1;
            e = sb.pop_front();
            compared++;
            if ({pc_out, stack_full, stack_empty, stack_err} !== {e.pc, e.full, e.empty, e.err}) begin
                mismatched++;
                $display("FAIL branch_step%0d: got pc=%h f/e/err=%b%b%b, want pc=%h f/e/err=%b%b%b", i,
                         pc_out, stack_full, stack_empty, stack_err, e.pc, e.full, e.empty, e.err);
            end
        end
    endtask

    task automatic test_nested_call();
        exp_t e;
        logic [1:0]  sel_t[5] = '{2'b01, 2'b11, 2'b11, 2'b11, 2'b11};
        logic [15:0] tgt_t[5] = '{16'h0010, 16'h0100, 16'h0200, 16'h0000, 16'h0000};
        logic        rt_t[5]  = '{0, 0, 0, 1, 1};
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, sel_t[i], tgt_t[i], 1'b0, rt_t[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            compared++;
            if ({pc_out, stack_full, stack_empty, stack_err} !== {e.pc, e.full, e.empty, e.err}) begin
                mismatched++;
                $display("FAIL nested_step%0d: got pc=%h f/e/err=%b%b%b, want pc=%h f/e/err=%b%b%b", i,
                         pc_out, stack_full, stack_empty, stack_err, e.pc, e.full, e.empty, e.err);
            end
        end
    endtask

    task automatic test_overflow();
        exp_t e;
        apply_reset();
        for (int i = 0; i <= DEPTH; i++) begin
            drive(1'b1, 2'b11, 16'h1000 + 16'(i), 1'b0, 1'b0);
            @(posedge clk); #1;
            e = sb.pop_front();
            compared++;
            if ({pc_out, stack_full, stack_empty, stack_err} !== {e.pc, e.full, e.empty, e.err}) begin
                mismatched++;
                $display("FAIL overflow_call%0d: got pc=%h f/e/err=%b%b%b, want pc=%h f/e/err=%b%b%b", i,
                         pc_out, stack_full, stack_empty, stack_err, e.pc, e.full, e.empty, e.err);
            end
        end
        apply_reset();
        compared++;
        if ({stack_err, stack_full, stack_empty} !== 3'b001) begin
            mismatched++;
            $display("FAIL err_cleared: got err/f/e=%b%b%b, want 001", stack_err, stack_full, stack_empty);
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 2'b11, 16'h0ABC, 1'b0, 1'b1);
            @(posedge clk); #1;
            e = sb.pop_front();
            compared++;
            if ({pc_out, stack_full, stack_empty, stack_err} !== {e.pc, e.full, e.empty, e.err}) begin
                mismatched++;
                $display("FAIL underflow_ret%0d: got pc=%h f/e/err=%b%b%b, want pc=%h f/e/err=%b%b%b", i,
                         pc_out, stack_full, stack_empty, stack_err, e.pc, e.full, e.empty, e.err);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic        en_t[6]  = '{1, 1, 1, 0, 0, 1};
        logic [1:0]  sel_t[6] = '{2'b01, 2'b11, 2'b11, 2'b11, 2'b01, 2'b10};
        logic [15:0] tgt_t[6] = '{16'h0050, 16'h0080, 16'h0000, 16'h0999, 16'h0888, 16'h0777};
        logic        rt_t[6]  = '{0, 0, 1, 0, 0, 0};
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            drive(en_t[i], sel_t[i], tgt_t[i], 1'b1, rt_t[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            compared++;
            if ({pc_out, stack_full, stack_empty, stack_err} !== {e.pc, e.full, e.empty, e.err}) begin
                mismatched++;
                $display("FAIL b2b_step%0d: got pc=%h f/e/err=%b%b%b, want pc=%h f/e/err=%b%b%b", i,
                         pc_out, stack_full, stack_empty, stack_err, e.pc, e.full, e.empty, e.err);
            end
        end
    endtask

    task automatic test_ret_on_empty_target();
        exp_t e;
        apply_reset();
        drive(1'b1, 2'b11, 16'h0300, 1'b0, 1'b1);
        @(posedge clk); #1;
        e = sb.pop_front();
        compared++;
        if ({pc_out, stack_full, stack_empty, stack_err} !== {e.pc, e.full, e.empty, e.err}) begin
            mismatched++;
            $display("FAIL sel11_ret1: got pc=%h f/e/err=%b%b%b, want pc=%h f/e/err=%b%b%b",
                     pc_out, stack_full, stack_empty, stack_err, e.pc, e.full, e.empty, e.err);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, want completion");
        $fatal(1);
    end

    initial begin
        m_pc = 16'h0000;
        m_err = 1'b0;
        test_reset();
        test_wrap();
        test_branch();
        test_nested_call();
        test_overflow();
        test_back_to_back();
        test_ret_on_empty_target();
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
